bram_true_dual_initiator: RTL and testbench

//  Initiator for a true dual-port block RAM. Two independent valid/ready request channels (A, B) become RAM port signals.

---
 rtl/bram_true_dual_initiator.sv | 183 ++++++++++++++++++
 tb/tb_bram_true_dual_initiator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_true_dual_initiator.sv
// Dual-port BRAM initiator: valid/ready request channels to RAM ports, per-port response FIFOs with
// credit flow control and deterministic collision handling. Optional: BRAM_TRUE_DUAL_INITIATOR_WR_FWD_EN.
module bram_true_dual_initiator #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  REQ_VALID_A,
  output logic                  REQ_READY_A,
  input  logic                  REQ_WE_A,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_A,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_A,
  output logic                  RESP_VALID_A,
  input  logic                  RESP_READY_A,
  output logic [DATA_WIDTH-1:0] RESP_DATA_A,
  output logic [DATA_WIDTH-1:0] RAM_DI_A,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_A,
  output logic                  RAM_WE_A,
  output logic                  RAM_RE_A,
  input  logic [DATA_WIDTH-1:0] RAM_DO_A,
  input  logic                  REQ_VALID_B,
  output logic                  REQ_READY_B,
  input  logic                  REQ_WE_B,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_B,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_B,
  output logic                  RESP_VALID_B,
  input  logic                  RESP_READY_B,
  output logic [DATA_WIDTH-1:0] RESP_DATA_B,
  output logic [DATA_WIDTH-1:0] RAM_DI_B,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_B,
  output logic                  RAM_WE_B,
  output logic                  RAM_RE_B,
  input  logic [DATA_WIDTH-1:0] RAM_DO_B
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic                  run_q;
  logic [1:0]            inflight_q;
  logic [CW-1:0]         occ_q    [2];
  logic [CW-1:0]         occ_d    [2];
  logic [PW-1:0]         wr_ptr_q [2];
  logic [PW-1:0]         wr_ptr_d [2];
  logic [PW-1:0]         rd_ptr_q [2];
  logic [PW-1:0]         rd_ptr_d [2];
  logic [DATA_WIDTH-1:0] fifo_q   [2][RESP_DEPTH];
  logic [DATA_WIDTH-1:0] push_data [2];
  logic [DATA_WIDTH-1:0] ram_do   [2];
  logic [1:0]            resp_ready;
  logic [1:0]            resp_valid;
  logic [1:0]            pop;
  logic [1:0]            push;
  logic [1:0]            credit_ok;
  logic [1:0]            fire_rd;
  logic                  same_addr;
  logic                  ready_a;
  logic                  ready_b;
  logic                  fire_a;
  logic                  fire_b;
  logic                  stall_b;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(RESP_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign resp_ready = {RESP_READY_B, RESP_READY_A};
  assign ram_do[0]  = RAM_DO_A;
  assign ram_do[1]  = RAM_DO_B;
  assign push       = inflight_q;

  // A read needs a free slot once queued and in-flight entries are counted; a same-cycle pop frees one.
  always_comb begin
    resp_valid = '0;
    pop        = '0;
    credit_ok  = '0;
    for (int p = 0; p < 2; p++) begin
      resp_valid[p] = (occ_q[p] != '0);
      pop[p]        = resp_valid[p] && resp_ready[p];
      credit_ok[p]  = ({1'b0, occ_q[p]} + {{CW{1'b0}}, inflight_q[p]}) <
                      ({1'b0, CW'(RESP_DEPTH)} + {{CW{1'b0}}, pop[p]});
      occ_d[p]      = occ_q[p];
      if (push[p] && !pop[p]) begin
        occ_d[p] = occ_q[p] + CW'(1);
      end else if (!push[p] && pop[p]) begin
        occ_d[p] = occ_q[p] - CW'(1);
      end
      wr_ptr_d[p] = push[p] ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
      rd_ptr_d[p] = pop[p]  ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
    end
  end

  always_comb begin
    same_addr = (REQ_ADDR_A == REQ_ADDR_B);
    ready_a   = run_q && (REQ_WE_A || credit_ok[0]);
    fire_a    = REQ_VALID_A && ready_a;
`ifdef BRAM_TRUE_DUAL_INITIATOR_WR_FWD_EN
    stall_b   = fire_a && same_addr && REQ_WE_A && REQ_WE_B;
`else
    stall_b   = fire_a && same_addr && (REQ_WE_A || REQ_WE_B);
`endif
    ready_b   = run_q && (REQ_WE_B || credit_ok[1]) && !stall_b;
    fire_b    = REQ_VALID_B && ready_b;
    fire_rd   = {fire_b && !REQ_WE_B, fire_a && !REQ_WE_A};
  end

  assign REQ_READY_A  = ready_a;
  assign REQ_READY_B  = ready_b;
  assign RAM_WE_A     = fire_a && REQ_WE_A;
  assign RAM_RE_A     = fire_rd[0];
  assign RAM_ADDR_A   = REQ_ADDR_A;
  assign RAM_DI_A     = REQ_DATA_A;
  assign RAM_WE_B     = fire_b && REQ_WE_B;
  assign RAM_RE_B     = fire_rd[1];
  assign RAM_ADDR_B   = REQ_ADDR_B;
  assign RAM_DI_B     = REQ_DATA_B;
  assign RESP_VALID_A = resp_valid[0];
  assign RESP_VALID_B = resp_valid[1];
  assign RESP_DATA_A  = fifo_q[0][rd_ptr_q[0]];
  assign RESP_DATA_B  = fifo_q[1][rd_ptr_q[1]];

`ifdef BRAM_TRUE_DUAL_INITIATOR_WR_FWD_EN
  // A read colliding with the other port's write takes that write's data; the RAM output is undefined.
  logic [1:0]            fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q [2];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      fwd_q         <= '0;
      fwd_data_q[0] <= '0;
      fwd_data_q[1] <= '0;
    end else begin
      fwd_q[0]      <= fire_rd[0] && fire_b && REQ_WE_B && same_addr;
      fwd_q[1]      <= fire_rd[1] && fire_a && REQ_WE_A && same_addr;
      fwd_data_q[0] <= REQ_DATA_B;
      fwd_data_q[1] <= REQ_DATA_A;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      push_data[p] = fwd_q[p] ? fwd_data_q[p] : ram_do[p];
    end
  end
`else
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      push_data[p] = ram_do[p];
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      run_q      <= 1'b0;
      inflight_q <= '0;
      for (int p = 0; p < 2; p++) begin
        occ_q[p]    <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
      end
    end else begin
      run_q      <= 1'b1;
      inflight_q <= fire_rd;
      for (int p = 0; p < 2; p++) begin
        occ_q[p]    <= occ_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        fifo_q[p][wr_ptr_q[p]] <= push_data[p];
      end
    end
  end

endmodule

// File: tb/tb_bram_true_dual_initiator.sv
// Randomized bench for bram_true_dual_initiator against an array/queue reference model and a behavioural RAM.
module tb_bram_true_dual_initiator;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int DEP = 2;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
`ifdef BRAM_TRUE_DUAL_INITIATOR_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESETN = 1'b1;
  logic          REQ_VALID_A = 1'b0, REQ_WE_A = 1'b0, RESP_READY_A = 1'b0;
  logic          REQ_VALID_B = 1'b0, REQ_WE_B = 1'b0, RESP_READY_B = 1'b0;
  logic [AW-1:0] REQ_ADDR_A = '0, REQ_ADDR_B = '0;
  logic [DW-1:0] REQ_DATA_A = '0, REQ_DATA_B = '0;
  logic          REQ_READY_A, REQ_READY_B, RESP_VALID_A, RESP_VALID_B;
  logic [DW-1:0] RESP_DATA_A, RESP_DATA_B, RAM_DI_A, RAM_DI_B;
  logic [AW-1:0] RAM_ADDR_A, RAM_ADDR_B;
  logic          RAM_WE_A, RAM_RE_A, RAM_WE_B, RAM_RE_B;
  logic [DW-1:0] RAM_DO_A, RAM_DO_B;

  always #5 CLK = ~CLK;

  bram_true_dual_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEP)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ_VALID_A(REQ_VALID_A), .REQ_READY_A(REQ_READY_A), .REQ_WE_A(REQ_WE_A),
    .REQ_ADDR_A(REQ_ADDR_A), .REQ_DATA_A(REQ_DATA_A),
    .RESP_VALID_A(RESP_VALID_A), .RESP_READY_A(RESP_READY_A), .RESP_DATA_A(RESP_DATA_A),
    .RAM_DI_A(RAM_DI_A), .RAM_ADDR_A(RAM_ADDR_A), .RAM_WE_A(RAM_WE_A), .RAM_RE_A(RAM_RE_A),
    .RAM_DO_A(RAM_DO_A),
    .REQ_VALID_B(REQ_VALID_B), .REQ_READY_B(REQ_READY_B), .REQ_WE_B(REQ_WE_B),
    .REQ_ADDR_B(REQ_ADDR_B), .REQ_DATA_B(REQ_DATA_B),
    .RESP_VALID_B(RESP_VALID_B), .RESP_READY_B(RESP_READY_B), .RESP_DATA_B(RESP_DATA_B),
    .RAM_DI_B(RAM_DI_B), .RAM_ADDR_B(RAM_ADDR_B), .RAM_WE_B(RAM_WE_B), .RAM_RE_B(RAM_RE_B),
    .RAM_DO_B(RAM_DO_B)
  );

  // True dual-port RAM, read-first; colliding accesses yield garbage, idle output is garbage too.
  logic [DW-1:0] ram [16];
  always @(posedge CLK) begin
    RAM_DO_A <= (RAM_RE_A && !(RAM_WE_B && RAM_ADDR_B == RAM_ADDR_A)) ? ram[RAM_ADDR_A] : 8'($urandom);
    RAM_DO_B <= (RAM_RE_B && !(RAM_WE_A && RAM_ADDR_A == RAM_ADDR_B)) ? ram[RAM_ADDR_B] : 8'($urandom);
    if (RAM_WE_A && RAM_WE_B && RAM_ADDR_A == RAM_ADDR_B) begin
      ram[RAM_ADDR_A] <= 8'($urandom);
    end else begin
      if (RAM_WE_A) ram[RAM_ADDR_A] <= RAM_DI_A;
      if (RAM_WE_B) ram[RAM_ADDR_B] <= RAM_DI_B;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mem [16];
  exp_t          qa[$];
  exp_t          qb[$];
  logic          rdy_a, rdy_b, rv_a, rv_b;
  logic [DW-1:0] rd_a, rd_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus; responses and accepted requests are scored against the model.
  task automatic step(input logic va, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic rra,
                      input logic vb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic rrb);
    logic fa, fb;
    exp_t e;
    @(negedge CLK);
    REQ_VALID_A = va; REQ_WE_A = wa; REQ_ADDR_A = aa; REQ_DATA_A = da; RESP_READY_A = rra;
    REQ_VALID_B = vb; REQ_WE_B = wb; REQ_ADDR_B = ab; REQ_DATA_B = db; RESP_READY_B = rrb;
    #1;
    rdy_a = REQ_READY_A; rdy_b = REQ_READY_B;
    rv_a  = RESP_VALID_A; rv_b = RESP_VALID_B;
    rd_a  = RESP_DATA_A;  rd_b = RESP_DATA_B;
    fa = va && rdy_a;
    fb = vb && rdy_b;

    if (rv_a) begin
      check("a_resp_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        check("a_resp_data", 32'(rd_a), 32'(qa[0].d));
        check("a_resp_latency", 32'((cyc - qa[0].c) >= 2), 32'd1);
        if (rra) void'(qa.pop_front());
      end
    end
    if (rv_b) begin
      check("b_resp_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        check("b_resp_data", 32'(rd_b), 32'(qb[0].d));
        check("b_resp_latency", 32'((cyc - qb[0].c) >= 2), 32'd1);
        if (rrb) void'(qb.pop_front());
      end
    end

    if (va && wa) check("a_wr_ready", 32'(rdy_a), 32'd1);
    if (vb && wb && !(fa && aa == ab)) check("b_wr_ready", 32'(rdy_b), 32'd1);
    if (fa && vb && aa == ab && ((wa && wb) || (!FWD && (wa || wb))))
      check("coll_b_stall", 32'(rdy_b), 32'd0);
    if (FWD && fa && vb && aa == ab && !wa && wb)
      check("fwd_b_nostall", 32'(rdy_b), 32'd1);

    if (fa && !wa) begin
      e.d = (fb && wb && ab == aa) ? db : mem[aa];
      e.c = cyc;
      qa.push_back(e);
      check("a_credit", 32'(qa.size() <= DEP), 32'd1);
    end
    if (fb && !wb) begin
      e.d = (fa && wa && aa == ab) ? da : mem[ab];
      e.c = cyc;
      qb.push_back(e);
      check("b_credit", 32'(qb.size() <= DEP), 32'd1);
    end
    if (fa && wa) mem[aa] = da;
    if (fb && wb) mem[ab] = db;
  endtask

  task automatic idle(input logic rra, input logic rrb);
    step(F, F, 4'd0, 8'd0, rra, F, F, 4'd0, 8'd0, rrb);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int            acc;
    logic [AW-1:0] ad;
    logic          rva, rwa, rra_r, rvb, rwb, rrb_r;
    logic [AW-1:0] raa, rab;
    logic [DW-1:0] rda, rdb;

    // Reset with a request pending: nothing may reach the RAM or the response side.
    REQ_VALID_A = 1'b1; REQ_WE_A = 1'b1; REQ_ADDR_A = 4'd3;
    #2 RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ready_a", 32'(REQ_READY_A), 32'd0);
    check("rst_ram_we_a", 32'(RAM_WE_A), 32'd0);
    check("rst_resp_valid_a", 32'(RESP_VALID_A), 32'd0);
    REQ_WE_A = 1'b0;
    #1;
    check("rst_ram_re_a", 32'(RAM_RE_A), 32'd0);
    check("rst_ready_b", 32'(REQ_READY_B), 32'd0);
    @(negedge CLK);
    REQ_VALID_A = 1'b0;
    RESETN = 1'b1;
    idle(T, T);
    idle(T, T);

    for (int i = 0; i < 8; i++) begin
      step(T, T, 4'(i), 8'($urandom), T, T, T, 4'(i + 8), 8'($urandom), T);
    end

    // Write then read back with exact two-cycle response latency.
    step(T, T, 4'd5, 8'h3C, T, F, F, 4'd0, 8'd0, T);
    step(T, F, 4'd5, 8'd0, T, F, F, 4'd0, 8'd0, T);
    check("basic_rd_ready", 32'(rdy_a), 32'd1);
    idle(T, T);
    check("basic_t1_no_resp", 32'(rv_a), 32'd0);
    idle(T, T);
    check("basic_t2_resp", 32'(rv_a), 32'd1);
    check("basic_data", 32'(rd_a), 32'h3C);

    // Backpressure: responses held, at most RESP_DEPTH reads accepted.
    acc = 0;
    ad  = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step(T, F, ad, 8'd0, F, F, F, 4'd0, 8'd0, T);
      if (rdy_a) begin
        acc++;
        ad = ad + 4'd1;
      end
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_ready_low", 32'(rdy_a), 32'd0);
    repeat (4) idle(T, T);
    check("bp_drained", 32'(qa.size()), 32'd0);

    // Write/write collision: B waits one cycle and its data lands last.
    step(T, T, 4'd7, 8'h11, T, T, T, 4'd7, 8'h22, T);
    check("ww_a_ready", 32'(rdy_a), 32'd1);
    check("ww_b_stall", 32'(rdy_b), 32'd0);
    step(F, F, 4'd0, 8'd0, T, T, T, 4'd7, 8'h22, T);
    check("ww_b_retry", 32'(rdy_b), 32'd1);
    step(T, F, 4'd7, 8'd0, T, F, F, 4'd0, 8'd0, T);
    idle(T, T);
    idle(T, T);
    check("ww_rd_valid", 32'(rv_a), 32'd1);
    check("ww_rd_data", 32'(rd_a), 32'h22);

    // Read/write collision: B must never see the old value.
    step(T, T, 4'd9, 8'h55, T, F, F, 4'd0, 8'd0, T);
    step(T, T, 4'd9, 8'hAA, T, T, F, 4'd9, 8'd0, T);
    check("rw_b_ready", 32'(rdy_b), 32'(FWD));
    if (!rdy_b) begin
      step(F, F, 4'd0, 8'd0, T, T, F, 4'd9, 8'd0, T);
      check("rw_b_retry", 32'(rdy_b), 32'd1);
    end
    idle(T, T);
    idle(T, T);
    check("rw_b_valid", 32'(rv_b), 32'd1);
    check("rw_b_data", 32'(rd_b), 32'hAA);

    // Random traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      rva   = ($urandom_range(3) != 0);
      rwa   = 1'($urandom_range(1));
      raa   = 4'($urandom_range(3));
      rda   = 8'($urandom);
      rra_r = ($urandom_range(3) != 0);
      rvb   = ($urandom_range(3) != 0);
      rwb   = 1'($urandom_range(1));
      rab   = 4'($urandom_range(3));
      rdb   = 8'($urandom);
      rrb_r = ($urandom_range(3) != 0);
      step(rva, rwa, raa, rda, rra_r, rvb, rwb, rab, rdb, rrb_r);
    end
    for (int i = 0; i < 20; i++) begin
      if (qa.size() != 0 || qb.size() != 0) idle(T, T);
    end
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);

    // Reset with one response queued and one read in flight: both must vanish.
    step(T, F, 4'd1, 8'd0, F, T, F, 4'd2, 8'd0, F);
    step(T, F, 4'd2, 8'd0, F, T, F, 4'd3, 8'd0, F);
    @(negedge CLK);
    REQ_VALID_A = 1'b0;
    REQ_VALID_B = 1'b0;
    RESETN = 1'b0;
    #1;
    check("midrst_valid_a", 32'(RESP_VALID_A), 32'd0);
    check("midrst_valid_b", 32'(RESP_VALID_B), 32'd0);
    qa.delete();
    qb.delete();
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (4) idle(T, T);
    check("post_rst_valid_a", 32'(rv_a), 32'd0);
    check("post_rst_valid_b", 32'(rv_b), 32'd0);
    step(T, F, 4'd5, 8'd0, T, F, F, 4'd0, 8'd0, T);
    check("post_rst_rd_ready", 32'(rdy_a), 32'd1);
    repeat (3) idle(T, T);
    check("post_rst_drain", 32'(qa.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
